// File: rtl/test_pkg.sv
// Shared types for the data-processing pipeline: FSM state encoding and the packet
// record handed from the processing stage to the collector.
package test_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'b00,
        LOAD    = 2'b01,
        PROCESS = 2'b10,
        DONE    = 2'b11
    } state_t;

    typedef struct packed {
        logic       valid;
        logic [7:0] data;
        logic [1:0] mode;
        logic       error;
    } packet_t;

    localparam int PKT_W = $bits(packet_t);

endpackage

// File: rtl/packet_collector_fifo.sv
// pkt_fifo: show-ahead synchronous FIFO with flush. Pointers carry an extra wrap bit
// so full and empty are distinguished without a separate counter.
module pkt_fifo #(
    parameter int WIDTH = 12,
    parameter int DEPTH = 4
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     flush_i,
    input  logic                     push_i,
    input  logic                     pop_i,
    input  logic [WIDTH-1:0]         wdata_i,
    output logic [WIDTH-1:0]         rdata_o,
    output logic                     full_o,
    output logic                     empty_o,
    output logic [$clog2(DEPTH):0]   level_o
);

    localparam int AW = $clog2(DEPTH);

    logic [AW:0]      wr_ptr_r;
    logic [AW:0]      rd_ptr_r;
    logic [WIDTH-1:0] mem_r [DEPTH];
    logic             full_s;
    logic             empty_s;
    logic             do_push_s;
    logic             do_pop_s;

    assign full_s  = (wr_ptr_r[AW-1:0] == rd_ptr_r[AW-1:0]) && (wr_ptr_r[AW] != rd_ptr_r[AW]);
    assign empty_s = (wr_ptr_r == rd_ptr_r);

    // A push into a full FIFO is legal only when the head leaves on the same edge.
    assign do_pop_s  = pop_i && !flush_i && !empty_s;
    assign do_push_s = push_i && !flush_i && (!full_s || do_pop_s);

    // Read/write pointer update; flush returns both to the origin.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_ptr_r <= {(AW+1){1'b0}};
            rd_ptr_r <= {(AW+1){1'b0}};
        end else if (flush_i) begin
            wr_ptr_r <= {(AW+1){1'b0}};
            rd_ptr_r <= {(AW+1){1'b0}};
        end else begin
            if (do_push_s) begin
                wr_ptr_r <= wr_ptr_r + {{AW{1'b0}}, 1'b1};
            end
            if (do_pop_s) begin
                rd_ptr_r <= rd_ptr_r + {{AW{1'b0}}, 1'b1};
            end
        end
    end

    // Storage array, cleared on reset so the head reads as zero before any write.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= {WIDTH{1'b0}};
            end
        end else if (do_push_s) begin
            mem_r[wr_ptr_r[AW-1:0]] <= wdata_i;
        end
    end

    assign rdata_o = mem_r[rd_ptr_r[AW-1:0]];
    assign full_o  = full_s;
    assign empty_o = empty_s;
    assign level_o = wr_ptr_r - rd_ptr_r;

endmodule

// File: rtl/packet_collector.sv
// packet_collector: captures one packet per rising edge of the upstream valid, buffers it
// in pkt_fifo and counts overflow drops. Define PKT_STATS_EN to enable the error counter.
module packet_collector
    import test_pkg::*;
#(
    parameter int DEPTH     = 4,
    parameter int CNT_WIDTH = 8
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     flush_i,
    input  logic                     pkt_valid_i,
    input  packet_t                  pkt_i,
    output logic                     out_valid_o,
    input  logic                     out_ready_i,
    output packet_t                  out_pkt_o,
    output logic                     full_o,
    output logic                     empty_o,
    output logic [$clog2(DEPTH):0]   level_o,
    output logic [CNT_WIDTH-1:0]     drop_cnt_o,
    output logic [CNT_WIDTH-1:0]     err_cnt_o
);

    logic                 live_s;
    logic                 prev_r;
    logic                 cap_s;
    logic                 pop_s;
    logic                 push_s;
    logic                 drop_s;
    logic                 full_s;
    logic                 empty_s;
    logic [PKT_W-1:0]     head_s;
    logic [CNT_WIDTH-1:0] drop_cnt_r;

    assign live_s  = pkt_valid_i & pkt_i.valid;
    assign cap_s   = live_s & ~prev_r;
    assign pop_s   = ~empty_s & out_ready_i;
    assign push_s  = cap_s & ~flush_i & (~full_s | pop_s);
    assign drop_s  = cap_s & ~flush_i & full_s & ~pop_s;

    // Edge detector state; keeps tracking through a flush so a held valid is not re-captured.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            prev_r <= 1'b0;
        end else begin
            prev_r <= live_s;
        end
    end

    // Saturating overflow counter.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            drop_cnt_r <= {CNT_WIDTH{1'b0}};
        end else if (drop_s && (drop_cnt_r != {CNT_WIDTH{1'b1}})) begin
            drop_cnt_r <= drop_cnt_r + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
        end
    end

`ifdef PKT_STATS_EN
    logic [CNT_WIDTH-1:0] err_cnt_r;

    // Saturating count of accepted packets flagged with an error.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            err_cnt_r <= {CNT_WIDTH{1'b0}};
        end else if (push_s && pkt_i.error && (err_cnt_r != {CNT_WIDTH{1'b1}})) begin
            err_cnt_r <= err_cnt_r + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
        end
    end

    assign err_cnt_o = err_cnt_r;
`else
    assign err_cnt_o = {CNT_WIDTH{1'b0}};
`endif

    pkt_fifo #(
        .WIDTH (PKT_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .flush_i (flush_i),
        .push_i  (push_s),
        .pop_i   (pop_s),
        .wdata_i (pkt_i),
        .rdata_o (head_s),
        .full_o  (full_s),
        .empty_o (empty_s),
        .level_o (level_o)
    );

    assign out_valid_o = ~empty_s;
    assign out_pkt_o   = packet_t'(head_s);
    assign full_o      = full_s;
    assign empty_o     = empty_s;
    assign drop_cnt_o  = drop_cnt_r;

endmodule

// File: tb/tb_packet_collector.sv
// Directed self-checking bench for packet_collector (DEPTH=4, CNT_WIDTH=8).
module tb_packet_collector;
    import test_pkg::*;

    logic       clk_i = 1'b0;
    logic       rst_i = 1'b1;
    logic       flush_i = 1'b0;
    logic       pkt_valid_i = 1'b0;
    packet_t    pkt_i = packet_t'(12'h000);
    logic       out_valid_o;
    logic       out_ready_i = 1'b0;
    packet_t    out_pkt_o;
    logic       full_o;
    logic       empty_o;
    logic [2:0] level_o;
    logic [7:0] drop_cnt_o;
    logic [7:0] err_cnt_o;

    int n_checks = 0;
    int n_fail   = 0;
    int exp_drop = 0;
    int exp_err  = 0;

    packet_collector #(.DEPTH(4), .CNT_WIDTH(8)) dut (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .flush_i     (flush_i),
        .pkt_valid_i (pkt_valid_i),
        .pkt_i       (pkt_i),
        .out_valid_o (out_valid_o),
        .out_ready_i (out_ready_i),
        .out_pkt_o   (out_pkt_o),
        .full_o      (full_o),
        .empty_o     (empty_o),
        .level_o     (level_o),
        .drop_cnt_o  (drop_cnt_o),
        .err_cnt_o   (err_cnt_o)
    );

    always #5 clk_i = ~clk_i;

    function automatic packet_t mk(input logic [7:0] d, input logic e);
        packet_t p;
        p.valid = 1'b1;
        p.data  = d;
        p.mode  = 2'b10;
        p.error = e;
        return p;
    endfunction

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic send(input logic [7:0] d, input logic e);
        pkt_i = mk(d, e);
        pkt_valid_i = 1'b1;
        tick();
        pkt_valid_i = 1'b0;
        tick();
    endtask

    task automatic test_reset();
        out_ready_i = 1'b0;
        send(8'h5C, 1'b0);
        n_checks++;
        if (level_o !== 3'd1) begin
            n_fail++;
            $display("FAIL reset_pre_level: got %0d expected 1", level_o);
        end
        @(negedge clk_i);
        #2;
        rst_i = 1'b1;
        #1;
        n_checks++;
        if (level_o !== 3'd0 || empty_o !== 1'b1 || full_o !== 1'b0 || out_valid_o !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_async_flags: got level=%0d empty=%b full=%b valid=%b expected 0/1/0/0",
                     level_o, empty_o, full_o, out_valid_o);
        end
        n_checks++;
        if (out_pkt_o !== packet_t'(12'h000) || drop_cnt_o !== 8'd0 || err_cnt_o !== 8'd0) begin
            n_fail++;
            $display("FAIL reset_async_data: got pkt=%h drop=%0d err=%0d expected 000/0/0",
                     out_pkt_o, drop_cnt_o, err_cnt_o);
        end
        tick();
        rst_i = 1'b0;
        tick();
        n_checks++;
        if (empty_o !== 1'b1 || out_valid_o !== 1'b0 || drop_cnt_o !== 8'd0) begin
            n_fail++;
            $display("FAIL reset_release: got empty=%b valid=%b drop=%0d expected 1/0/0",
                     empty_o, out_valid_o, drop_cnt_o);
        end
    endtask

    task automatic test_held_valid();
        int beats;
        out_ready_i = 1'b1;
        // Upstream valid without the packet's own valid bit must not capture.
        pkt_i = mk(8'h3C, 1'b0);
        pkt_i.valid = 1'b0;
        pkt_valid_i = 1'b1;
        tick();
        tick();
        n_checks++;
        if (empty_o !== 1'b1) begin
            n_fail++;
            $display("FAIL held_invalid_bit: got empty=%b expected 1", empty_o);
        end
        pkt_valid_i = 1'b0;
        tick();
        pkt_i = mk(8'hA5, 1'b0);
        pkt_valid_i = 1'b1;
        tick();
        n_checks++;
        if (out_valid_o !== 1'b1 || out_pkt_o.data !== 8'hA5 || out_pkt_o.mode !== 2'b10) begin
            n_fail++;
            $display("FAIL held_first_beat: got valid=%b data=%h mode=%b expected 1/a5/10",
                     out_valid_o, out_pkt_o.data, out_pkt_o.mode);
        end
        beats = 0;
        for (int i = 0; i < 6; i++) begin
            if (out_valid_o === 1'b1) beats++;
            if (i == 3) pkt_valid_i = 1'b0;
            tick();
        end
        n_checks++;
        if (beats != 1) begin
            n_fail++;
            $display("FAIL held_beats: got %0d expected 1", beats);
        end
    endtask

    task automatic test_overflow();
        out_ready_i = 1'b0;
        for (int i = 1; i <= 6; i++) send(8'(i), 1'b0);
        exp_drop += 2;
        n_checks++;
        if (full_o !== 1'b1 || level_o !== 3'd4 || drop_cnt_o !== 8'(exp_drop)) begin
            n_fail++;
            $display("FAIL overflow_state: got full=%b level=%0d drop=%0d expected 1/4/%0d",
                     full_o, level_o, drop_cnt_o, exp_drop);
        end
        out_ready_i = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            n_checks++;
            if (out_valid_o !== 1'b1 || out_pkt_o.data !== 8'(i)) begin
                n_fail++;
                $display("FAIL overflow_drain_%0d: got valid=%b data=%h expected 1/%h",
                         i, out_valid_o, out_pkt_o.data, 8'(i));
            end
            tick();
        end
        n_checks++;
        if (empty_o !== 1'b1) begin
            n_fail++;
            $display("FAIL overflow_empty: got %b expected 1", empty_o);
        end
    endtask

    task automatic test_full_pop_cap();
        logic [7:0] exp_q [4];
        exp_q[0] = 8'h12; exp_q[1] = 8'h13; exp_q[2] = 8'h14; exp_q[3] = 8'h77;
        out_ready_i = 1'b0;
        for (int i = 0; i < 4; i++) send(8'h11 + 8'(i), 1'b0);
        pkt_i = mk(8'h77, 1'b0);
        pkt_valid_i = 1'b1;
        out_ready_i = 1'b1;
        tick();
        pkt_valid_i = 1'b0;
        n_checks++;
        if (level_o !== 3'd4 || full_o !== 1'b1 || drop_cnt_o !== 8'(exp_drop)) begin
            n_fail++;
            $display("FAIL fullpc_state: got level=%0d full=%b drop=%0d expected 4/1/%0d",
                     level_o, full_o, drop_cnt_o, exp_drop);
        end
        for (int i = 0; i < 4; i++) begin
            n_checks++;
            if (out_valid_o !== 1'b1 || out_pkt_o.data !== exp_q[i]) begin
                n_fail++;
                $display("FAIL fullpc_drain_%0d: got valid=%b data=%h expected 1/%h",
                         i, out_valid_o, out_pkt_o.data, exp_q[i]);
            end
            tick();
        end
    endtask

    task automatic test_flush();
        out_ready_i = 1'b0;
        for (int i = 0; i < 3; i++) send(8'h21 + 8'(i), 1'b0);
        n_checks++;
        if (level_o !== 3'd3) begin
            n_fail++;
            $display("FAIL flush_pre_level: got %0d expected 3", level_o);
        end
        pkt_i = mk(8'h99, 1'b1);
        pkt_valid_i = 1'b1;
        flush_i = 1'b1;
        out_ready_i = 1'b1;
        tick();
        flush_i = 1'b0;
        n_checks++;
        if (level_o !== 3'd0 || out_valid_o !== 1'b0 || empty_o !== 1'b1) begin
            n_fail++;
            $display("FAIL flush_cleared: got level=%0d valid=%b empty=%b expected 0/0/1",
                     level_o, out_valid_o, empty_o);
        end
        tick();
        tick();
        n_checks++;
        if (level_o !== 3'd0 || drop_cnt_o !== 8'(exp_drop) || err_cnt_o !== 8'(exp_err)) begin
            n_fail++;
            $display("FAIL flush_no_recapture: got level=%0d drop=%0d err=%0d expected 0/%0d/%0d",
                     level_o, drop_cnt_o, err_cnt_o, exp_drop, exp_err);
        end
        pkt_valid_i = 1'b0;
        tick();
    endtask

    task automatic test_stats();
        out_ready_i = 1'b0;
        send(8'h41, 1'b1);
        send(8'h42, 1'b0);
        send(8'h43, 1'b1);
        send(8'h44, 1'b0);
        send(8'h45, 1'b1);
        exp_drop += 1;
`ifdef PKT_STATS_EN
        exp_err += 2;
`endif
        n_checks++;
        if (err_cnt_o !== 8'(exp_err) || drop_cnt_o !== 8'(exp_drop)) begin
            n_fail++;
            $display("FAIL stats_err: got err=%0d drop=%0d expected %0d/%0d",
                     err_cnt_o, drop_cnt_o, exp_err, exp_drop);
        end
        flush_i = 1'b1;
        tick();
        flush_i = 1'b0;
    endtask

    task automatic test_saturation();
        out_ready_i = 1'b0;
        for (int i = 0; i < 4; i++) send(8'h50 + 8'(i), 1'b0);
        for (int i = 0; i < 300; i++) begin
            send(8'h60, 1'b0);
            exp_drop = (exp_drop >= 255) ? 255 : exp_drop + 1;
        end
        n_checks++;
        if (drop_cnt_o !== 8'(exp_drop) || exp_drop != 255) begin
            n_fail++;
            $display("FAIL sat_drop: got %0d expected 255", drop_cnt_o);
        end
        n_checks++;
        if (level_o !== 3'd4 || out_pkt_o.data !== 8'h50 || err_cnt_o !== 8'(exp_err)) begin
            n_fail++;
            $display("FAIL sat_fifo: got level=%0d head=%h err=%0d expected 4/50/%0d",
                     level_o, out_pkt_o.data, err_cnt_o, exp_err);
        end
        #3;
        rst_i = 1'b1;
        #1;
        n_checks++;
        if (drop_cnt_o !== 8'd0 || err_cnt_o !== 8'd0 || level_o !== 3'd0) begin
            n_fail++;
            $display("FAIL sat_reset: got drop=%0d err=%0d level=%0d expected 0/0/0",
                     drop_cnt_o, err_cnt_o, level_o);
        end
        tick();
        rst_i = 1'b0;
        tick();
    endtask

    initial begin
        tick();
        tick();
        rst_i = 1'b0;
        tick();
        test_reset();
        test_held_valid();
        test_overflow();
        test_full_pop_cap();
        test_flush();
        test_stats();
        test_saturation();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
